// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, default parameters
// and the counter-width helper.
package reset_seq_pkg;

    localparam int unsigned DefNumStages  = 3;
    localparam int unsigned DefStageDelay = 16;
    localparam int unsigned DefLockFilter = 4;
    localparam int unsigned DefAckTimeout = 255;

    typedef enum logic [2:0] {
        StHold,
        StFilter,
        StRelease,
        StAckWait,
        StDone
    } seq_state_e;

    // Wide enough to hold the largest terminal count without wrapping.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/lock_filter.sv
// Lock debounce: qualified_o pulses when lock_i has been high for LOCK_FILTER consecutive
// cycles while enabled; any low cycle, clear or disable restarts the count.
module lock_filter
    import reset_seq_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = DefLockFilter,
    parameter int unsigned CNT_W       = cnt_width(DefStageDelay, DefLockFilter, DefAckTimeout)
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic lock_i,
    input  logic clr_i,
    output logic qualified_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             counting;

    assign counting = en_i & lock_i & ~clr_i;

    always_comb begin
        cnt_d = '0;
        if (counting) begin
            cnt_d = (cnt_q == CNT_W'(LOCK_FILTER)) ? cnt_q : cnt_q + CNT_W'(1);
        end
    end

    assign qualified_o = counting & (cnt_q == CNT_W'(LOCK_FILTER - 1));

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release. Edge 0 is the first rising edge that samples lock=1 in HOLD;
// stage k deasserts at edge LOCK_FILTER+(k+1)*STAGE_DELAY exactly (offset 0), done with
// the last stage. Optional RESET_SEQ_ACK_EN adds a per-stage acknowledge wait with timeout.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NUM_STAGES  = DefNumStages,
    parameter int unsigned STAGE_DELAY = DefStageDelay,
    parameter int unsigned LOCK_FILTER = DefLockFilter,
    parameter int unsigned ACK_TIMEOUT = DefAckTimeout
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] stage_rdy,
    output logic [NUM_STAGES-1:0] stage_rst,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CntW = cnt_width(STAGE_DELAY, LOCK_FILTER, ACK_TIMEOUT);
    localparam int unsigned IdxW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    seq_state_e            state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  filt_ok;

    lock_filter #(
        .LOCK_FILTER (LOCK_FILTER),
        .CNT_W       (CntW)
    ) u_lock_filter (
        .clk_i       (clk),
        .reset_i     (reset),
        .en_i        (state_q == StFilter),
        .lock_i      (lock),
        .clr_i       (restart),
        .qualified_o (filt_ok)
    );

`ifndef RESET_SEQ_ACK_EN
    logic unused_rdy;
    assign unused_rdy = ^stage_rdy;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        stage_rst_d = stage_rst_q;
        done_d      = done_q;
        err_d       = err_q;
        // Lock loss wins over restart; both collapse to a single HOLD entry.
        if (!lock || (restart && state_q != StHold)) begin
            state_d     = StHold;
            cnt_d       = '0;
            idx_d       = '0;
            stage_rst_d = '1;
            done_d      = 1'b0;
        end else begin
            unique case (state_q)
                StHold: begin
                    cnt_d       = '0;
                    idx_d       = '0;
                    stage_rst_d = '1;
                    done_d      = 1'b0;
                    state_d     = StFilter;
                end
                StFilter: begin
                    if (filt_ok) begin
                        state_d = StRelease;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end
                end
                StRelease: begin
                    if (cnt_q == CntW'(STAGE_DELAY - 1)) begin
                        stage_rst_d[idx_q] = 1'b0;
                        cnt_d              = '0;
                        if (idx_q == IdxW'(NUM_STAGES - 1)) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
`ifdef RESET_SEQ_ACK_EN
                            state_d = StAckWait;
`else
                            idx_d   = idx_q + IdxW'(1);
`endif
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`ifdef RESET_SEQ_ACK_EN
                StAckWait: begin
                    if (stage_rdy[idx_q] || cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                        if (!stage_rdy[idx_q]) err_d = 1'b1;
                        state_d = StRelease;
                        idx_d   = idx_q + IdxW'(1);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
`endif
                StDone: begin
                    done_d      = 1'b1;
                    stage_rst_d = '0;
                end
                default: begin
                    state_d = StHold;
                end
            endcase
        end
`ifndef RESET_SEQ_ACK_EN
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StHold;
            cnt_q       <= '0;
            idx_q       <= '0;
            stage_rst_q <= '1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            stage_rst_q <= stage_rst_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign stage_rst = stage_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
